// File: rtl/blur_pkg.sv
// Types and per-channel arithmetic shared by the horblur/vertblur pixel path.
// Combinational helpers only; no latency and no flow control.
package blur_pkg;

    localparam int CH_W   = 8;
    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g1;
        logic [CH_W-1:0] g2;
        logic [CH_W-1:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        ROW0,
        ROW1,
        STEADY
    } row_state_e;

    // Unnormalised [1 2 1] sum; 10 bits always suffice for 8-bit taps.
    function automatic logic [CH_W+1:0] ch_kernel3(
        input logic [CH_W-1:0] far_tap,
        input logic [CH_W-1:0] mid_tap,
        input logic [CH_W-1:0] near_tap
    );
        return {2'b00, far_tap} + {1'b0, mid_tap, 1'b0} + {2'b00, near_tap};
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port synchronous RAM, read-before-write; rdata_o valid 1 cycle after en_i.
// No flow control; contents are not reset.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vertblur.sv
// Causal 3-row [1 2 1]/4 vertical blur per channel; adds +2 rounding when VERTBLUR_ROUND_EN is defined.
// Latency 2 cycles; no backpressure, in_valid gaps simply hold the pipeline.
module vertblur
    import blur_pkg::*;
#(
    parameter int LINE_WIDTH = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic [31:0] data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic [31:0] blur,
    output logic        err_line_len
);

    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
`ifdef VERTBLUR_ROUND_EN
    localparam logic [CH_W+1:0] RND = (CH_W+2)'(2);
`else
    localparam logic [CH_W+1:0] RND = '0;
`endif

    function automatic logic [CH_W-1:0] ch_norm(input logic [CH_W+1:0] sum);
        return CH_W'((sum + RND) >> 2);
    endfunction

    function automatic pixel_t blur3(input pixel_t f, input pixel_t m, input pixel_t n);
        pixel_t o;
        o.r  = ch_norm(ch_kernel3(f.r,  m.r,  n.r));
        o.g1 = ch_norm(ch_kernel3(f.g1, m.g1, n.g1));
        o.g2 = ch_norm(ch_kernel3(f.g2, m.g2, n.g2));
        o.b  = ch_norm(ch_kernel3(f.b,  m.b,  n.b));
        return o;
    endfunction

    row_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             err_q, err_d;
    logic             sel_q, sel_d;

    logic             accept;
    row_state_e       px_state;
    logic [COL_W-1:0] px_col;
    logic             line_end;

    assign accept   = in_valid && (in_sof || (state_q != IDLE));
    assign px_state = in_sof ? ROW0 : state_q;
    assign px_col   = in_sof ? '0 : col_q;
    assign line_end = in_eol || (px_col == LAST_COL);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        err_d   = err_q;
        sel_d   = sel_q;
        if (accept) begin
            state_d = px_state;
            col_d   = line_end ? '0 : px_col + 1'b1;
            if (in_eol && (px_col != LAST_COL)) begin
                err_d = 1'b1;
            end
            if (line_end) begin
                sel_d = ~sel_q;
                case (px_state)
                    ROW0:    state_d = ROW1;
                    ROW1:    state_d = STEADY;
                    default: state_d = px_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            err_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
        end
    end

    // The two RAMs swap roles each line instead of copying row y-1 into row y-2:
    // sel_q=0 means RAM0 holds row y-1 and RAM1 holds row y-2 (overwritten by the new row).
    logic [31:0] rd0, rd1;

    line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(32)) u_lb0 (
        .clk     (clk),
        .en_i    (accept),
        .we_i    (accept && sel_q),
        .addr_i  (px_col),
        .wdata_i (data),
        .rdata_o (rd0)
    );

    line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(32)) u_lb1 (
        .clk     (clk),
        .en_i    (accept),
        .we_i    (accept && !sel_q),
        .addr_i  (px_col),
        .wdata_i (data),
        .rdata_o (rd1)
    );

    logic       v1_q, sof1_q, eol1_q, sel1_q;
    pixel_t     px1_q;
    row_state_e st1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= accept;
        end
        if (accept) begin
            sof1_q <= in_sof;
            eol1_q <= in_eol;
            sel1_q <= sel_q;
            px1_q  <= data;
            st1_q  <= px_state;
        end
    end

    pixel_t row_a, row_b, tap1, tap2, blur_d;

    always_comb begin
        row_a  = sel1_q ? rd1 : rd0;
        row_b  = sel1_q ? rd0 : rd1;
        tap1   = px1_q;
        tap2   = px1_q;
        case (st1_q)
            ROW1: begin
                tap1 = row_a;
                tap2 = row_a;
            end
            STEADY: begin
                tap1 = row_a;
                tap2 = row_b;
            end
            default: ;
        endcase
        blur_d = blur3(tap2, tap1, px1_q);
    end

    logic        valid_q, osof_q, oeol_q;
    logic [31:0] blur_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            osof_q  <= 1'b0;
            oeol_q  <= 1'b0;
            blur_q  <= '0;
        end else begin
            valid_q <= v1_q;
            osof_q  <= v1_q && sof1_q;
            oeol_q  <= v1_q && eol1_q;
            if (v1_q) begin
                blur_q <= blur_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_sof      = osof_q;
    assign out_eol      = oeol_q;
    assign blur         = blur_q;
    assign err_line_len = err_q;

endmodule

// File: tb/tb_vertblur.sv
// Directed bench for vertblur at LINE_WIDTH=4; expected pixels are hand-computed constants.
module tb_vertblur;

    localparam int LW = 4;
`ifdef VERTBLUR_ROUND_EN
    localparam logic [31:0] R1 = 32'h40404040;
    localparam logic [31:0] R2 = 32'h80808080;
`else
    localparam logic [31:0] R1 = 32'h3F3F3F3F;
    localparam logic [31:0] R2 = 32'h7F7F7F7F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [31:0] data = '0;
    logic        out_valid, out_sof, out_eol, err_line_len;
    logic [31:0] blur;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit gaps_on = 1'b0;

    int          in_cyc_q[$];
    logic [31:0] obs_dat_q[$];
    logic        obs_sof_q[$];
    logic        obs_eol_q[$];
    int          obs_cyc_q[$];
    logic [31:0] exp_q[$];

    vertblur #(.LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_eol       (in_eol),
        .data         (data),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .blur         (blur),
        .err_line_len (err_line_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            obs_dat_q.push_back(blur);
            obs_sof_q.push_back(out_sof);
            obs_eol_q.push_back(out_eol);
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic clearq();
        in_cyc_q.delete();
        obs_dat_q.delete();
        obs_sof_q.delete();
        obs_eol_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_eol   = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e);
        if (gaps_on && ($urandom_range(0, 1) == 1)) idle(1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        data     = d;
        in_sof   = s;
        in_eol   = e;
        in_cyc_q.push_back(cyc);
    endtask

    task automatic send_row(input logic [31:0] v, input int n, input bit sof_first, input bit eol_last);
        for (int i = 0; i < n; i++) begin
            send(v, sof_first && (i == 0), eol_last && (i == n - 1));
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearq();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sof, out_eol, err_line_len} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_sof, out_eol, err_line_len});
        end
        checks++;
        if (blur !== 32'h0) begin
            errors++;
            $display("FAIL reset_blur: got %h expected 00000000", blur);
        end
        // A pixel in flight when rst hits must never appear.
        send(32'hDEADBEEF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflight: out_valid got %b expected 0", out_valid);
        end
        idle(3);
        checks++;
        if (obs_dat_q.size() != 0) begin
            errors++;
            $display("FAIL reset_discard: got %0d outputs expected 0", obs_dat_q.size());
        end
        clearq();
    endtask

    task automatic test_constant();
        reset_dut();
        for (int r = 0; r < 3; r++) send_row(32'h10203040, LW, r == 0, 1'b1);
        idle(4);
        checks++;
        if (obs_dat_q.size() != 12) begin
            errors++;
            $display("FAIL const_count: got %0d expected 12", obs_dat_q.size());
        end
        for (int i = 0; i < 12 && i < obs_dat_q.size(); i++) begin
            checks++;
            if (obs_dat_q[i] !== 32'h10203040 || obs_sof_q[i] !== (i == 0) || obs_eol_q[i] !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL const_out[%0d]: got %h sof %b eol %b expected 10203040 sof %b eol %b",
                         i, obs_dat_q[i], obs_sof_q[i], obs_eol_q[i], i == 0, i % 4 == 3);
            end
            checks++;
            if (obs_cyc_q[i] - in_cyc_q[i] != 2) begin
                errors++;
                $display("FAIL const_latency[%0d]: got %0d expected 2", i, obs_cyc_q[i] - in_cyc_q[i]);
            end
        end
    endtask

    task automatic test_pattern(input bit gaps);
        reset_dut();
        gaps_on = gaps;
        send_row(32'h00000000, LW, 1'b1, 1'b1);
        send_row(32'hFFFFFFFF, LW, 1'b0, 1'b1);
        send_row(32'h00000000, LW, 1'b0, 1'b1);
        gaps_on = 1'b0;
        idle(4);
        for (int i = 0; i < LW; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < LW; i++) exp_q.push_back(R1);
        for (int i = 0; i < LW; i++) exp_q.push_back(R2);
        checks++;
        if (obs_dat_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pattern_count gaps=%0d: got %0d expected %0d", gaps, obs_dat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_dat_q.size(); i++) begin
            checks++;
            if (obs_dat_q[i] !== exp_q[i] || (obs_cyc_q[i] - in_cyc_q[i]) != 2) begin
                errors++;
                $display("FAIL pattern_out[%0d] gaps=%0d: got %h lat %0d expected %h lat 2",
                         i, gaps, obs_dat_q[i], obs_cyc_q[i] - in_cyc_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturate();
        reset_dut();
        // No in_eol at all: the column counter must wrap silently.
        for (int i = 0; i < 4 * LW; i++) send(32'hFFFFFFFF, i == 0, 1'b0);
        idle(4);
        checks++;
        if (obs_dat_q.size() != 4 * LW) begin
            errors++;
            $display("FAIL sat_count: got %0d expected %0d", obs_dat_q.size(), 4 * LW);
        end
        for (int i = 0; i < 4 * LW && i < obs_dat_q.size(); i++) begin
            checks++;
            if (obs_dat_q[i] !== 32'hFFFFFFFF || obs_eol_q[i] !== 1'b0) begin
                errors++;
                $display("FAIL sat_out[%0d]: got %h eol %b expected ffffffff eol 0", i, obs_dat_q[i], obs_eol_q[i]);
            end
        end
        checks++;
        if (err_line_len !== 1'b0) begin
            errors++;
            $display("FAIL sat_noerr: err_line_len got %b expected 0", err_line_len);
        end
    endtask

    task automatic test_line_err();
        reset_dut();
        send_row(32'h00000000, LW, 1'b1, 1'b1);
        send_row(32'hFFFFFFFF, 3, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (err_line_len !== 1'b0) begin
            errors++;
            $display("FAIL lenerr_early: got %b expected 0", err_line_len);
        end
        send(32'h00000000, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (err_line_len !== 1'b1) begin
            errors++;
            $display("FAIL lenerr_set: got %b expected 1", err_line_len);
        end
        send(32'h00000000, 1'b0, 1'b0);
        send(32'h00000000, 1'b0, 1'b1);
        idle(6);
        checks++;
        if (err_line_len !== 1'b1) begin
            errors++;
            $display("FAIL lenerr_sticky: got %b expected 1", err_line_len);
        end
        for (int i = 0; i < LW; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(R1);
        for (int i = 0; i < 3; i++) exp_q.push_back(R2);
        checks++;
        if (obs_dat_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL lenerr_count: got %0d expected %0d", obs_dat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_dat_q.size(); i++) begin
            checks++;
            if (obs_dat_q[i] !== exp_q[i] || obs_eol_q[i] !== (i == 3 || i == 6 || i == 9)) begin
                errors++;
                $display("FAIL lenerr_out[%0d]: got %h eol %b expected %h eol %b",
                         i, obs_dat_q[i], obs_eol_q[i], exp_q[i], i == 3 || i == 6 || i == 9);
            end
        end
    endtask

    task automatic test_resof();
        reset_dut();
        send_row(32'h00000000, LW, 1'b1, 1'b1);
        send_row(32'hFFFFFFFF, LW, 1'b0, 1'b1);
        send(32'h00000000, 1'b0, 1'b0);
        send(32'hA0B0C0D0, 1'b1, 1'b0);
        send(32'h11223344, 1'b0, 1'b0);
        send(32'h55667788, 1'b0, 1'b0);
        send(32'h99AABBCC, 1'b0, 1'b1);
        idle(4);
        for (int i = 0; i < LW; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < LW; i++) exp_q.push_back(R1);
        exp_q.push_back(R2);
        exp_q.push_back(32'hA0B0C0D0);
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'h55667788);
        exp_q.push_back(32'h99AABBCC);
        checks++;
        if (obs_dat_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL resof_count: got %0d expected %0d", obs_dat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_dat_q.size(); i++) begin
            checks++;
            if (obs_dat_q[i] !== exp_q[i] || obs_sof_q[i] !== (i == 0 || i == 9)) begin
                errors++;
                $display("FAIL resof_out[%0d]: got %h sof %b expected %h sof %b",
                         i, obs_dat_q[i], obs_sof_q[i], exp_q[i], i == 0 || i == 9);
            end
        end
        checks++;
        if (err_line_len !== 1'b0) begin
            errors++;
            $display("FAIL resof_noerr: got %b expected 0", err_line_len);
        end
    endtask

    task automatic test_pre_sof();
        reset_dut();
        send(32'h01010101, 1'b0, 1'b0);
        send(32'h02020202, 1'b0, 1'b0);
        send(32'h03030303, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (obs_dat_q.size() != 0) begin
            errors++;
            $display("FAIL presof_drop: got %0d outputs expected 0", obs_dat_q.size());
        end
        clearq();
        send(32'h01020304, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (obs_dat_q.size() != 1) begin
            errors++;
            $display("FAIL presof_first_count: got %0d expected 1", obs_dat_q.size());
        end else begin
            checks++;
            if (obs_dat_q[0] !== 32'h01020304 || obs_sof_q[0] !== 1'b1) begin
                errors++;
                $display("FAIL presof_first: got %h sof %b expected 01020304 sof 1", obs_dat_q[0], obs_sof_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_pattern(1'b0);
        test_pattern(1'b1);
        test_saturate();
        test_line_err();
        test_resof();
        test_pre_sof();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
